// File: rtl/pwm_fall_detect.sv
// pwm_fall_detect: WTA-PWM front end.
// Synchronises PWM inputs and emits per-frame falling-edge pulses.
//
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   i_pwm       asynchronous PWM inputs, one bit per channel
//   i_start     frame request, honoured only in IDLE
//   o_fall      one-cycle fall pulses, at most one per channel per frame
//   o_seen      channels that fell in the current/last frame
//   o_busy      frame in progress (ARM or RUN)
//   o_done      one-cycle pulse at frame end
//   o_timeout   last frame ended on the cycle timer
module pwm_fall_detect #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] i_pwm,
    input  logic            i_start,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_seen,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [TIMEOUT_W-1:0] TMAX = '1;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
    logic [N_CH-1:0] prev_q, prev_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic [N_CH-1:0] seen_q, seen_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic tout_q, tout_d;

    logic [N_CH-1:0] s;
    logic [N_CH-1:0] fall_raw;
    logic [N_CH-1:0] seen_all;
    logic [TIMEOUT_W-1:0] timer_inc;

    // Element 0 takes the raw input; the oldest stage is the clean copy.
    assign s        = sync_q[SYNC_STAGES-1];
    assign fall_raw = prev_q & ~s;
    assign seen_all = seen_q | fall_raw;
    assign timer_inc = timer_q + TIMEOUT_W'(1);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_pwm};
        prev_d = s;
    end

    always_comb begin
        state_d = state_q;
        fall_d  = '0;
        seen_d  = seen_q;
        timer_d = timer_q;
        tout_d  = tout_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    seen_d  = '0;
                    timer_d = '0;
                    tout_d  = 1'b0;
                    state_d = ARM;
                end
            end
            ARM: begin
                // Wait until every channel is high: start of a period.
                if (&s) begin
                    timer_d = '0;
                    state_d = RUN;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMAX) begin
                        tout_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                fall_d  = fall_raw & ~seen_q;
                seen_d  = seen_all;
                timer_d = timer_inc;
                // All-fallen wins over a timeout on the same cycle.
                if (&seen_all) begin
                    state_d = DONE;
                end else if (timer_inc == TMAX) begin
                    tout_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            prev_q  <= '0;
            fall_q  <= '0;
            seen_q  <= '0;
            timer_q <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            fall_q  <= fall_d;
            seen_q  <= seen_d;
            timer_q <= timer_d;
            tout_q  <= tout_d;
        end
    end

    assign o_fall    = fall_q;
    assign o_seen    = seen_q;
    assign o_timeout = tout_q;
    assign o_busy    = (state_q == ARM) || (state_q == RUN);
    assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_pwm_fall_detect.sv
// tb_pwm_fall_detect: directed bench for pwm_fall_detect.
// Runs with TIMEOUT_W=4 so each phase lasts 15 cycles.
module tb_pwm_fall_detect;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_pwm;
    logic       i_start;
    logic [7:0] o_fall;
    logic [7:0] o_seen;
    logic       o_busy;
    logic       o_done;
    logic       o_timeout;

    int n_vec = 0;
    int n_err = 0;

    pwm_fall_detect #(
        .N_CH       (8),
        .SYNC_STAGES(2),
        .TIMEOUT_W  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pwm    (i_pwm),
        .i_start  (i_start),
        .o_fall   (o_fall),
        .o_seen   (o_seen),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [7:0] v);
        i_pwm = v;
        repeat (3) tick();
    endtask

    // Leaves the DUT just after the edge that entered RUN.
    task automatic start_frame();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [18:0] outs;
        rst_n   = 1'b0;
        i_pwm   = 8'hFF;
        i_start = 1'b0;
        repeat (2) tick();
        outs = {o_fall, o_seen, o_busy, o_done, o_timeout};
        n_vec++;
        if (outs !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outs got %h exp 0", outs);
        end
        rst_n = 1'b1;
        settle(8'hFF);
        n_vec++;
        if (o_busy !== 1'b0 || o_fall !== 8'h00) begin
            n_err++;
            $display("FAIL reset_idle busy=%b fall=%h exp 0/00",
                     o_busy, o_fall);
        end
    endtask

    task automatic test_normal_frame();
        logic [7:0] ef;
        logic       ed;
        settle(8'hFF);
        start_frame();
        n_vec++;
        if (o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL normal_busy got %b exp 1", o_busy);
        end
        for (int c = 1; c <= 13; c++) begin
            case (c - 1)
                0: i_pwm = 8'hF7;
                5: i_pwm = 8'hF6;
                9: i_pwm = 8'h00;
                default: ;
            endcase
            tick();
            ef = (c == 3)  ? 8'h08 :
                 (c == 8)  ? 8'h01 :
                 (c == 12) ? 8'hF6 : 8'h00;
            ed = (c == 12);
            n_vec++;
            if (o_fall !== ef) begin
                n_err++;
                $display("FAIL normal_fall c=%0d got %h exp %h",
                         c, o_fall, ef);
            end
            n_vec++;
            if (o_done !== ed) begin
                n_err++;
                $display("FAIL normal_done c=%0d got %b exp %b",
                         c, o_done, ed);
            end
        end
        n_vec++;
        if (o_seen !== 8'hFF || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL normal_end seen=%h to=%b busy=%b exp FF/0/0",
                     o_seen, o_timeout, o_busy);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] ef;
        logic       ed;
        settle(8'hFF);
        start_frame();
        for (int c = 1; c <= 12; c++) begin
            case (c - 1)
                0: i_pwm = 8'hFB;
                2: i_pwm = 8'hFF;
                4: i_pwm = 8'hFB;
                8: i_pwm = 8'h00;
                default: ;
            endcase
            tick();
            ef = (c == 3)  ? 8'h04 :
                 (c == 11) ? 8'hFB : 8'h00;
            ed = (c == 11);
            n_vec++;
            if (o_fall !== ef) begin
                n_err++;
                $display("FAIL glitch_fall c=%0d got %h exp %h",
                         c, o_fall, ef);
            end
            n_vec++;
            if (o_done !== ed) begin
                n_err++;
                $display("FAIL glitch_done c=%0d got %b exp %b",
                         c, o_done, ed);
            end
            if (c == 4) begin
                n_vec++;
                if (o_seen !== 8'h04) begin
                    n_err++;
                    $display("FAIL glitch_seen got %h exp 04", o_seen);
                end
            end
        end
        n_vec++;
        if (o_seen !== 8'hFF) begin
            n_err++;
            $display("FAIL glitch_seen_end got %h exp FF", o_seen);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] ef;
        logic       ed;
        settle(8'hFF);
        start_frame();
        for (int c = 1; c <= 16; c++) begin
            if (c == 1) i_pwm = 8'h80;
            tick();
            ef = (c == 3) ? 8'h7F : 8'h00;
            ed = (c == 15);
            n_vec++;
            if (o_fall !== ef) begin
                n_err++;
                $display("FAIL tmo_fall c=%0d got %h exp %h",
                         c, o_fall, ef);
            end
            n_vec++;
            if (o_done !== ed) begin
                n_err++;
                $display("FAIL tmo_done c=%0d got %b exp %b",
                         c, o_done, ed);
            end
            if (c == 15) begin
                n_vec++;
                if (o_timeout !== 1'b1 || o_seen !== 8'h7F) begin
                    n_err++;
                    $display("FAIL tmo_flags to=%b seen=%h exp 1/7F",
                             o_timeout, o_seen);
                end
            end
        end
        n_vec++;
        if (o_timeout !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_hold to=%b busy=%b exp 1/0",
                     o_timeout, o_busy);
        end
    endtask

    task automatic test_arm_timeout();
        logic ed;
        settle(8'hFD);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_vec++;
        if (o_busy !== 1'b1 || o_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL arm_enter busy=%b to=%b exp 1/0",
                     o_busy, o_timeout);
        end
        for (int a = 1; a <= 16; a++) begin
            if (a == 3) i_pwm = 8'hED;
            tick();
            ed = (a == 15);
            n_vec++;
            if (o_done !== ed) begin
                n_err++;
                $display("FAIL arm_done a=%0d got %b exp %b",
                         a, o_done, ed);
            end
            n_vec++;
            if (o_fall !== 8'h00) begin
                n_err++;
                $display("FAIL arm_fall a=%0d got %h exp 00", a, o_fall);
            end
            if (a == 15) begin
                n_vec++;
                if (o_timeout !== 1'b1 || o_seen !== 8'h00) begin
                    n_err++;
                    $display("FAIL arm_flags to=%b seen=%h exp 1/00",
                             o_timeout, o_seen);
                end
            end
        end
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL arm_end busy got %b exp 0", o_busy);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] ef;
        logic       ed;
        bit         got;
        settle(8'hFF);
        start_frame();
        for (int c = 1; c <= 17; c++) begin
            case (c - 1)
                0:  i_pwm = 8'h80;
                10: i_start = 1'b1;
                12: i_pwm = 8'h00;
                default: ;
            endcase
            tick();
            ef = (c == 3)  ? 8'h7F :
                 (c == 15) ? 8'h80 : 8'h00;
            ed = (c == 15);
            n_vec++;
            if (o_fall !== ef) begin
                n_err++;
                $display("FAIL bnd_fall c=%0d got %h exp %h",
                         c, o_fall, ef);
            end
            n_vec++;
            if (o_done !== ed) begin
                n_err++;
                $display("FAIL bnd_done c=%0d got %b exp %b",
                         c, o_done, ed);
            end
            if (c == 15) begin
                n_vec++;
                if (o_timeout !== 1'b0 || o_seen !== 8'hFF) begin
                    n_err++;
                    $display("FAIL bnd_flags to=%b seen=%h exp 0/FF",
                             o_timeout, o_seen);
                end
            end
            if (c == 16) begin
                n_vec++;
                if (o_busy !== 1'b0 || o_seen !== 8'hFF) begin
                    n_err++;
                    $display("FAIL bnd_idle busy=%b seen=%h exp 0/FF",
                             o_busy, o_seen);
                end
            end
            if (c == 17) begin
                n_vec++;
                if (o_busy !== 1'b1 || o_seen !== 8'h00) begin
                    n_err++;
                    $display("FAIL bnd_restart busy=%b seen=%h exp 1/00",
                             o_busy, o_seen);
                end
            end
        end
        i_start = 1'b0;
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            tick();
            if (o_done === 1'b1) got = 1'b1;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL bnd_drain got no done exp done in 40 cycles");
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [18:0] outs;
        settle(8'hFF);
        start_frame();
        for (int c = 1; c <= 4; c++) begin
            if (c == 1) i_pwm = 8'hF0;
            if (c == 4) i_pwm = 8'h00;
            tick();
        end
        n_vec++;
        if (o_seen !== 8'h0F || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre seen=%h busy=%b exp 0F/1",
                     o_seen, o_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {o_fall, o_seen, o_busy, o_done, o_timeout};
        n_vec++;
        if (outs !== 19'd0) begin
            n_err++;
            $display("FAIL rstmid_outs got %h exp 0", outs);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++;
            if (o_fall !== 8'h00 || o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_post c=%0d fall=%h busy=%b exp 00/0",
                         c, o_fall, o_busy);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal_frame();
        test_glitch();
        test_timeout();
        test_arm_timeout();
        test_boundary();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
